crack_result_display: RTL and testbench



---
 rtl/crack_display_pkg.sv | 15 +
 rtl/SevenSegmentDisplayDecoder.sv | 31 +++
 rtl/crack_result_display.sv | 137 +++++++++++++
 tb/tb_crack_result_display.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/crack_display_pkg.sv
// Shared types and glyph constants for the crack result display.
package crack_display_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_FOUND  = 2'd1,
    ST_FAIL   = 2'd2
  } disp_state_t;

  localparam int         NUM_DIGITS = 6;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_DASH   = 7'h3F;
  localparam logic [6:0] SEG_ZERO   = 7'h40;

endpackage

// File: rtl/SevenSegmentDisplayDecoder.sv
// Hex nibble to active-low seven-segment pattern (bit0 = a ... bit6 = g).
module SevenSegmentDisplayDecoder (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Pure lookup; one font entry per hex digit.
  always_comb begin
    segments = 7'h7F;
    unique case (nibble)
      4'h0: segments = 7'h40;
      4'h1: segments = 7'h79;
      4'h2: segments = 7'h24;
      4'h3: segments = 7'h30;
      4'h4: segments = 7'h19;
      4'h5: segments = 7'h12;
      4'h6: segments = 7'h02;
      4'h7: segments = 7'h78;
      4'h8: segments = 7'h00;
      4'h9: segments = 7'h10;
      4'hA: segments = 7'h08;
      4'hB: segments = 7'h03;
      4'hC: segments = 7'h46;
      4'hD: segments = 7'h21;
      4'hE: segments = 7'h06;
      4'hF: segments = 7'h0E;
      default: segments = 7'h7F;
    endcase
  end

endmodule

// File: rtl/crack_result_display.sv
// Status stage after rc4_crack_controller: shows the live candidate key at a
// slow refresh rate while searching, then holds the found key or a dash glyph.
// Optional blinking of the found key is enabled by defining
// CRACK_DISPLAY_BLINK_EN.
module crack_result_display
  import crack_display_pkg::*;
#(
  parameter int REFRESH_DIV = 5_000_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] secret_key,
  input  logic        finish,
  input  logic        valid,
  input  logic [3:0]  crack_core_id,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        led_busy,
  output logic        led_found,
  output logic        led_fail,
  output logic [3:0]  shown_core_id
);

  localparam int             REF_W    = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  // Divisors below 2 would leave the counters with no terminal count.
  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("REFRESH_DIV must be >= 2");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("BLINK_DIV must be >= 2");
  end

  disp_state_t      state;
  logic [23:0]      disp_key;
  logic [REF_W-1:0] refresh_cnt;

  // Main FSM: periodic live sampling in SEARCH, capture on finish,
  // sticky result states until finish drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_SEARCH;
      disp_key      <= '0;
      shown_core_id <= '0;
      refresh_cnt   <= '0;
    end else begin
      unique case (state)
        ST_SEARCH: begin
          if (finish) begin
            // Finish capture takes priority over a coincident refresh sample.
            refresh_cnt <= '0;
            if (valid) begin
              state         <= ST_FOUND;
              disp_key      <= secret_key;
              shown_core_id <= crack_core_id;
            end else begin
              state <= ST_FAIL;
            end
          end else if (refresh_cnt == REF_LAST) begin
            refresh_cnt <= '0;
            disp_key    <= secret_key;
          end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
          end
        end
        default: begin
          if (!finish) begin
            state       <= ST_SEARCH;
            refresh_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign led_busy  = (state == ST_SEARCH);
  assign led_found = (state == ST_FOUND);
  assign led_fail  = (state == ST_FAIL);

`ifdef CRACK_DISPLAY_BLINK_EN
  localparam int               BLK_W    = $clog2(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;

  // Blink timer: parked at the start of an "on" half-period outside FOUND,
  // so every entry into FOUND begins with the key visible.
  always_ff @(posedge clk) begin
    if (reset || state != ST_FOUND) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`endif

  logic [NUM_DIGITS-1:0][3:0] key_nib;
  logic [NUM_DIGITS-1:0][6:0] seg_dec;
  logic [NUM_DIGITS-1:0][6:0] seg_out;

  assign key_nib = disp_key;

  SevenSegmentDisplayDecoder u_dec [NUM_DIGITS-1:0] (
    .nibble   (key_nib),
    .segments (seg_dec)
  );

  // Glyph override after the decoders: dashes on failure, blank in blink-off.
  always_comb begin
    seg_out = seg_dec;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (state == ST_FAIL) seg_out[i] = SEG_DASH;
`ifdef CRACK_DISPLAY_BLINK_EN
      else if (state == ST_FOUND && !blink_on) seg_out[i] = SEG_BLANK;
`endif
    end
  end

  assign hex0 = seg_out[0];
  assign hex1 = seg_out[1];
  assign hex2 = seg_out[2];
  assign hex3 = seg_out[3];
  assign hex4 = seg_out[4];
  assign hex5 = seg_out[5];

endmodule

// File: tb/tb_crack_result_display.sv
// Randomised plus directed bench for crack_result_display with a behavioural
// model counting edges since entering SEARCH / FOUND.
module tb_crack_result_display;

  localparam int RD = 4;
  localparam int BD = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] secret_key;
  logic        finish, valid;
  logic [3:0]  crack_core_id;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        led_busy, led_found, led_fail;
  logic [3:0]  shown_core_id;

  crack_result_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .secret_key(secret_key), .finish(finish),
    .valid(valid), .crack_core_id(crack_core_id),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .led_busy(led_busy), .led_found(led_found), .led_fail(led_fail),
    .shown_core_id(shown_core_id)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E };

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  // Model: mode 0 search, 1 found, 2 fail.
  int          m_mode = 0;
  logic [23:0] m_key = '0;
  logic [3:0]  m_id = '0;
  int          m_sedges = 0;
  int          m_fedges = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] exp_digit(input int d);
    logic [3:0] nib;
    nib = m_key[d*4 +: 4];
    if (m_mode == 2) return 7'h3F;
`ifdef CRACK_DISPLAY_BLINK_EN
    if (m_mode == 1 && ((m_fedges / BD) % 2) == 1) return 7'h7F;
`endif
    return FONT[nib];
  endfunction

  // Reference model advanced on each active edge from the stable inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_key = '0; m_id = '0; m_sedges = 0; m_fedges = 0;
    end else if (m_mode == 0) begin
      if (finish) begin
        if (valid) begin
          m_mode = 1; m_key = secret_key; m_id = crack_core_id; m_fedges = 0;
        end else begin
          m_mode = 2;
        end
      end else begin
        m_sedges++;
        if (m_sedges % RD == 0) m_key = secret_key;
      end
    end else begin
      if (!finish) begin
        m_mode = 0; m_sedges = 0;
      end else if (m_mode == 1) begin
        m_fedges++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hex0", 24'(hex0), 24'(exp_digit(0)));
      chk("hex1", 24'(hex1), 24'(exp_digit(1)));
      chk("hex2", 24'(hex2), 24'(exp_digit(2)));
      chk("hex3", 24'(hex3), 24'(exp_digit(3)));
      chk("hex4", 24'(hex4), 24'(exp_digit(4)));
      chk("hex5", 24'(hex5), 24'(exp_digit(5)));
      chk("led_busy",  24'(led_busy),  24'(m_mode == 0));
      chk("led_found", 24'(led_found), 24'(m_mode == 1));
      chk("led_fail",  24'(led_fail),  24'(m_mode == 2));
      chk("shown_core_id", 24'(shown_core_id), 24'(m_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset = 1'b1; finish = 1'b0; valid = 1'b0;
    secret_key = 24'hABCDEF; crack_core_id = 4'd0;
    tick();
    chk_en = 1;
    tick();
    reset = 1'b0;

    // Reset state, hand-computed.
    chk("rst_hex0", 24'(hex0), 24'h40);
    chk("rst_hex5", 24'(hex5), 24'h40);
    chk("rst_busy", 24'(led_busy), 24'd1);
    chk("rst_found", 24'(led_found), 24'd0);
    chk("rst_id", 24'(shown_core_id), 24'd0);

    // Live sample appears after the 4th edge.
    repeat (3) tick();
    chk("pre_sample_hex0", 24'(hex0), 24'h40);
    tick();
    chk("sample_hex0", 24'(hex0), 24'h0E);
    chk("sample_hex5", 24'(hex5), 24'h08);

    // Found capture with key change afterwards.
    finish = 1'b1; valid = 1'b1; secret_key = 24'h0003FF; crack_core_id = 4'd5;
    tick();
    secret_key = 24'h123456; valid = 1'b0; crack_core_id = 4'd9;
    chk("found_led", 24'(led_found), 24'd1);
    chk("found_hex0", 24'(hex0), 24'h0E);
    chk("found_hex2", 24'(hex2), 24'h30);
    chk("found_hex3", 24'(hex3), 24'h40);
    chk("found_id", 24'(shown_core_id), 24'd5);
    tick();
    chk("found_hold_hex1", 24'(hex1), 24'h0E);

    // Back to search, then failure.
    finish = 1'b0;
    tick();
    finish = 1'b1; valid = 1'b0;
    tick();
    chk("fail_led", 24'(led_fail), 24'd1);
    chk("fail_hex0", 24'(hex0), 24'h3F);
    chk("fail_hex5", 24'(hex5), 24'h3F);
    finish = 1'b0;
    tick();
    chk("ret_busy", 24'(led_busy), 24'd1);
    chk("ret_hex2", 24'(hex2), 24'h30);

    // Finish coincides with refresh terminal count.
    secret_key = 24'h00BEEF;
    repeat (3) tick();
    finish = 1'b1; valid = 1'b1; crack_core_id = 4'd3;
    tick();
    chk("tc_found", 24'(led_found), 24'd1);
    chk("tc_hex1", 24'(hex1), 24'h06);
    chk("tc_hex3", 24'(hex3), 24'h03);
    chk("tc_id", 24'(shown_core_id), 24'd3);
    secret_key = 24'h777777;
    repeat (12) tick();

    // Randomised phase.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) finish = ~finish;
      valid = 1'($urandom);
      secret_key = 24'($urandom);
      crack_core_id = 4'($urandom);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
